i2c_master_txn: RTL
===================

// Module: i2c_master_txn
// PURPOSE
//  Byte-oriented I2C master; executes one complete transaction per start pulse: START, addr+R/W, N data bytes, STOP.
//  Sits directly upstream of the ADC read FSM: consumes its start/rd_nwr/slave_addr/din/bytes_num, returns dout and done.
//  Drives the ADC bus through open-drain pull-low enables; the pads/tristates live at top level. No clock stretching, single master.
// PARAMETERS
//  CLK_FREQ_HZ               125_000_000  system clock frequency
//  I2C_FREQ_HZ               100_000      SCL frequency
//  MAX_BYTES_PER_TRANSACTION 3            size of din/dout arrays
//  (derived) QTR = CLK_FREQ_HZ/(4*I2C_FREQ_HZ); 312 clk per quarter SCL period at defaults
// PORTS
//  clk           in   1      system clock
//  reset         in   1      asynchronous, active-high reset
//  start         in   1      1-cycle request; accepted only when busy=0
//  rd_nwr        in   1      1=read data bytes, 0=write data bytes
//  slave_addr    in   7      7-bit target address
//  bytes_num     in   $clog2(MAX+1)  data bytes; 0=address-only; >MAX clamped to MAX
//  din           in   8 x MAX  write bytes, din[0] sent first
//  dout          out  8 x MAX  read bytes, dout[0] received first
//  done          out  1      1-cycle pulse when STOP completes
//  busy          out  1      high from accepted start until done
//  ack_error     out  1      last transaction saw slave NACK; valid with done
//  scl_drive_low out  1      1 = pull SCL low, 0 = release
//  sda_drive_low out  1      1 = pull SDA low, 0 = release
//  sda_in        in   1      SDA pad level (2-flop synchronised internally)
// BEHAVIOUR
//  Reset: all outputs 0, lines released, dout all 8'h00, state IDLE; reset mid-transfer releases both lines immediately, no done.
//  Accept: start&&!busy latches rd_nwr, addr, din, clamped bytes_num; busy=1 next cycle. start while busy ignored.
//  Timing: quarter-tick counter 0..QTR-1; each bit = 4 quarters: Q0 SCL low and SDA updated, Q1 low, Q2 SCL released, Q3 high.
//  SDA sampled at Q3 entry (mid SCL-high); SDA changes only while SCL low, except START/STOP.
//  States: IDLE -> START -> ADDR(8 bits: addr,rd_nwr) -> ADDR_ACK -> {WR_BYTE -> WR_ACK | RD_BYTE -> RD_ACK}* -> STOP -> IDLE.
//  START: SCL high, SDA pulled low for 2 quarters, then SCL low. STOP: SDA low, SCL released, then SDA released 2 quarters later.
//  Bits MSB first. Slave ACK = sda_in low at sample; high = NACK.
//  NACK on address or any write byte: ack_error=1, go straight to STOP; remaining bytes skipped.
//  Reads: master drives ACK (low) after every byte except the last, NACK (released) after last; dout[i] updated at byte completion.
//  Unread dout entries keep previous values. bytes_num=0: ADDR_ACK -> STOP.
//  done pulses 1 cycle when STOP finishes, same cycle busy falls; ack_error held until next accepted start (cleared there).
//  Next start may be accepted in the cycle after done; bus-free time between STOP and next START >= 4 quarters.
// TESTING
//  Write 0x48 bytes {01,42,43}, slave ACKs all -> SDA stream 0x90,A,0x01,A,0x42,A,0x43,A, STOP; done once; ack_error=0.
//  Read 0x48 n=2, slave drives 0x12,0x34 -> dout[0]=12, dout[1]=34; master ACK after byte0, NACK after byte1; dout[2] unchanged.
//  Address NACK (no slave) -> STOP right after addr bit9; done pulses, ack_error=1; start during busy produces no second txn.
//  SCL period = 1250 clk at defaults, SDA stable whenever SCL high except START/STOP; bytes_num=0 -> addr-only txn.
//  Assert reset mid-byte of a 3-byte write -> both drive_low=0 immediately, busy=0, no done; next start runs cleanly.

Source files
------------

// File: rtl/i2c_master_txn.sv
// rtl/i2c_master_txn.sv - byte-oriented I2C master running one full transaction per start pulse
//
// Purpose: executes START, address+R/W, up to MAX_BYTES_PER_TRANSACTION data
// bytes and STOP for every accepted start. Bus lines are open-drain pull-low
// enables; pads live at the top level. Single master, no clock stretching.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   i_start             1-cycle request, accepted only while o_busy=0
//   i_rd_nwr            1 = read data bytes, 0 = write data bytes
//   i_slave_addr        7-bit target address
//   i_bytes_num         data byte count, 0 = address only, clamped to MAX
//   i_din               write bytes, byte 0 in bits [7:0], sent first
//   o_dout              read bytes, byte 0 in bits [7:0], received first
//   o_done              1-cycle pulse when STOP completes
//   o_busy              high from accepted start until done
//   o_ack_error         slave NACK seen in the last transaction
//   o_scl_drive_low     1 = pull SCL low
//   o_sda_drive_low     1 = pull SDA low
//   i_sda_in            SDA pad level, synchronised internally

module i2c_master_txn #(
    parameter int CLK_FREQ_HZ               = 125_000_000,
    parameter int I2C_FREQ_HZ               = 100_000,
    parameter int MAX_BYTES_PER_TRANSACTION = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          i_start,
    input  logic                                          i_rd_nwr,
    input  logic [6:0]                                    i_slave_addr,
    input  logic [$clog2(MAX_BYTES_PER_TRANSACTION+1)-1:0] i_bytes_num,
    input  logic [8*MAX_BYTES_PER_TRANSACTION-1:0]        i_din,
    output logic [8*MAX_BYTES_PER_TRANSACTION-1:0]        o_dout,
    output logic                                          o_done,
    output logic                                          o_busy,
    output logic                                          o_ack_error,
    output logic                                          o_scl_drive_low,
    output logic                                          o_sda_drive_low,
    input  logic                                          i_sda_in
);

    localparam int MAX  = MAX_BYTES_PER_TRANSACTION;
    localparam int BW   = $clog2(MAX + 1);
    localparam int QTR  = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    // Clocks lost to the integer quarter are added back to the odd quarters
    // (end of SCL low, end of SCL high) so one bit is exactly CLK/I2C clocks.
    localparam int REM  = CLK_FREQ_HZ / I2C_FREQ_HZ - 4 * QTR;
    localparam int EXT1 = (REM + 1) / 2;
    localparam int EXT3 = REM / 2;
    localparam int QW   = $clog2(QTR + EXT1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t              r_state;
    logic [QW-1:0]       r_qcnt;
    logic [2:0]          r_quarter;
    logic [2:0]          r_bit;
    logic [BW-1:0]       r_byte;
    logic [BW-1:0]       r_nbytes;
    logic                r_rd;
    logic [7:0]          r_shift;
    logic [8*MAX-1:0]    r_din;
    logic [8*MAX-1:0]    r_dout;
    logic                r_sample;
    logic                r_done;
    logic                r_busy;
    logic                r_ack_error;
    logic                r_scl_low;
    logic                r_sda_low;
    logic                r_sda_s1;
    logic                r_sda_s2;

    logic [QW-1:0]       w_qend;
    logic                w_qtick;
    logic [BW-1:0]       w_byte_nxt;
    logic [BW-1:0]       w_din_idx;
    logic [7:0]          w_din_byte;

    always_comb begin
        w_qend = QW'(QTR - 1);
        if (r_quarter[1:0] == 2'd1)
            w_qend = QW'(QTR - 1 + EXT1);
        else if (r_quarter[1:0] == 2'd3)
            w_qend = QW'(QTR - 1 + EXT3);
    end

    assign w_qtick    = (r_qcnt == w_qend);
    assign w_byte_nxt = r_byte + 1'b1;
    // The first data byte starts from ADDR_ACK (index 0); later ones from WR_ACK.
    assign w_din_idx  = (r_state == S_ADDR_ACK) ? r_byte : w_byte_nxt;
    assign w_din_byte = r_din[{w_din_idx, 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            r_quarter   <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_nbytes    <= '0;
            r_rd        <= 1'b0;
            r_shift     <= '0;
            r_din       <= '0;
            r_dout      <= '0;
            r_sample    <= 1'b1;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_ack_error <= 1'b0;
            r_scl_low   <= 1'b0;
            r_sda_low   <= 1'b0;
            r_sda_s1    <= 1'b1;
            r_sda_s2    <= 1'b1;
        end else begin
            r_sda_s1 <= i_sda_in;
            r_sda_s2 <= r_sda_s1;
            r_done   <= 1'b0;

            if (r_state == S_IDLE) begin
                r_qcnt    <= '0;
                r_quarter <= '0;
                if (i_start) begin
                    r_state     <= S_START;
                    r_busy      <= 1'b1;
                    r_ack_error <= 1'b0;
                    r_rd        <= i_rd_nwr;
                    r_shift     <= {i_slave_addr, i_rd_nwr};
                    r_din       <= i_din;
                    r_nbytes    <= (i_bytes_num > BW'(MAX)) ? BW'(MAX) : i_bytes_num;
                    r_byte      <= '0;
                    r_bit       <= '0;
                end
            end else if (!w_qtick) begin
                r_qcnt <= r_qcnt + 1'b1;
            end else begin
                r_qcnt    <= '0;
                r_quarter <= r_quarter + 1'b1;
                case (r_state)
                    // Q0 bus idle, Q1-Q2 SDA low with SCL high, then first address bit.
                    S_START: begin
                        if (r_quarter == 3'd0) begin
                            r_sda_low <= 1'b1;
                        end else if (r_quarter == 3'd2) begin
                            r_state   <= S_ADDR;
                            r_quarter <= '0;
                            r_bit     <= '0;
                            r_scl_low <= 1'b1;
                            r_sda_low <= ~r_shift[7];
                        end
                    end
                    // Q0-Q1 both low, SCL up at Q2, SDA up at Q4, Q4-Q7 bus-free gap.
                    S_STOP: begin
                        case (r_quarter)
                            3'd1: r_scl_low <= 1'b0;
                            3'd3: r_sda_low <= 1'b0;
                            3'd7: begin
                                r_state   <= S_IDLE;
                                r_quarter <= '0;
                                r_done    <= 1'b1;
                                r_busy    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        if (r_quarter == 3'd1) begin
                            r_scl_low <= 1'b0;
                        end else if (r_quarter == 3'd2) begin
                            r_sample <= r_sda_s2;
                            if (r_state == S_RD_BYTE)
                                r_shift <= {r_shift[6:0], r_sda_s2};
                        end else if (r_quarter == 3'd3) begin
                            // Bit boundary: SCL goes low and the next SDA level is set together.
                            r_quarter <= '0;
                            r_scl_low <= 1'b1;
                            case (r_state)
                                S_ADDR, S_WR_BYTE: begin
                                    if (r_bit != 3'd7) begin
                                        r_bit     <= r_bit + 1'b1;
                                        r_shift   <= {r_shift[6:0], 1'b0};
                                        r_sda_low <= ~r_shift[6];
                                    end else begin
                                        r_state   <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                                        r_sda_low <= 1'b0;
                                    end
                                end
                                S_ADDR_ACK, S_WR_ACK: begin
                                    if (r_sample) begin
                                        r_ack_error <= 1'b1;
                                        r_state     <= S_STOP;
                                        r_sda_low   <= 1'b1;
                                    end else if ((r_state == S_ADDR_ACK && r_nbytes == '0) ||
                                                 (r_state == S_WR_ACK && w_byte_nxt == r_nbytes)) begin
                                        r_state   <= S_STOP;
                                        r_sda_low <= 1'b1;
                                    end else begin
                                        if (r_state == S_WR_ACK)
                                            r_byte <= w_byte_nxt;
                                        r_bit <= '0;
                                        if (r_rd) begin
                                            r_state   <= S_RD_BYTE;
                                            r_sda_low <= 1'b0;
                                        end else begin
                                            r_state   <= S_WR_BYTE;
                                            r_shift   <= w_din_byte;
                                            r_sda_low <= ~w_din_byte[7];
                                        end
                                    end
                                end
                                S_RD_BYTE: begin
                                    if (r_bit != 3'd7) begin
                                        r_bit     <= r_bit + 1'b1;
                                        r_sda_low <= 1'b0;
                                    end else begin
                                        // r_shift already holds the eighth sample.
                                        r_state   <= S_RD_ACK;
                                        r_dout[{r_byte, 3'b000} +: 8] <= r_shift;
                                        r_sda_low <= (w_byte_nxt != r_nbytes);
                                    end
                                end
                                S_RD_ACK: begin
                                    if (w_byte_nxt == r_nbytes) begin
                                        r_state   <= S_STOP;
                                        r_sda_low <= 1'b1;
                                    end else begin
                                        r_byte    <= w_byte_nxt;
                                        r_bit     <= '0;
                                        r_state   <= S_RD_BYTE;
                                        r_sda_low <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign o_dout          = r_dout;
    assign o_done          = r_done;
    assign o_busy          = r_busy;
    assign o_ack_error     = r_ack_error;
    assign o_scl_drive_low = r_scl_low;
    assign o_sda_drive_low = r_sda_low;

endmodule
